instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Program sequencer for the simple CPU. Fetches 20-bit instructions from a sync instruction ROM.
//  Presents each to the CU `instr` input for exactly as many cycles as the CU FSM spends on it.
//  The CU has no handshake, so the sequencer paces it from the class bits instr[19:18].
//  Sits between instruction ROM and CU; replaces the testbench-driven instr stimulus.
// PARAMETERS
//  INSTR_WIDTH  20  instruction width (class field = [19:18])
//  PC_BITS      5   PC / ROM address width (32 instructions)
//  PROG_LEN     32  last valid address = PROG_LEN-1; must be <= 2**PC_BITS
// PORTS
//  clk         in   1            system clock, rising edge
//  rst         in   1            synchronous, active-low reset
//  run         in   1            level; rising into IDLE starts program at PC 0
//  halt_req    in   1            pulse; stop at next instruction boundary
//  loop_en     in   1            1: wrap PC to 0 after PROG_LEN-1; 0: finish
//  imem_en     out  1            ROM read enable
//  imem_addr   out  PC_BITS      ROM address
//  imem_data   in   INSTR_WIDTH  ROM data, valid the cycle after imem_en
//  instr       out  INSTR_WIDTH  to CU.instr (registered)
//  pc          out  PC_BITS      address of instruction currently on instr
//  busy        out  1            high in FETCH/LOAD/ISSUE
//  done        out  1            high in DONE
// BEHAVIOUR
//  Reset (rst==0 at posedge, any state):
//  - state=IDLE; instr=0; pc=0; imem_en=0; imem_addr=0; busy=0; done=0.
//  - hold counter and halt_pend cleared.
//  Hold counts by class:
//  - 01 std_op = 3 (DEC, EXE, WB); 10 loadR = 4 (DEC, EXE, MEM, WB); 11 storeR = 3 (DEC, EXE, MEM).
//  - The first instruction after IDLE gets +1 to cover the CU RESET->DECODE cycle.
//  States:
//  - IDLE: instr=0. When run==1 -> FETCH, pc=0.
//  - FETCH: imem_en=1, imem_addr=pc -> LOAD.
//  - LOAD: imem_data valid.
//    - Class 00: go to DONE; instr stays 0; 00 is the end-of-program marker and is never issued.
//    - Otherwise: instr<=imem_data, cnt<=hold(+1 if first) -> ISSUE.
//  - ISSUE: cnt decrements every cycle.
//    - cnt==2: prefetch. imem_en=1, imem_addr=next_pc.
//      - next_pc = pc+1.
//      - pc==PROG_LEN-1 and loop_en: next_pc=0.
//      - pc==PROG_LEN-1 and !loop_en: no prefetch, end flagged.
//    - cnt==1 (boundary), in priority order:
//      1. halt_pend or end flagged -> DONE, instr<=0.
//      2. fetched class 00 -> DONE, instr<=0.
//      3. else instr<=imem_data, pc<=next_pc, cnt<=hold(new class); stay ISSUE.
//    - Result: instr changes on the same edge the CU re-enters DECODE. No bubbles.
//  - DONE: done=1, instr=0. When run==0 -> IDLE.
//  halt_req:
//  - Latched into sticky halt_pend in ISSUE; cleared on DONE entry.
//  - Ignored in IDLE/DONE; in FETCH/LOAD it is latched and honoured at the first boundary.
//  - halt_req and prefetch in the same cycle: the prefetch occurs, but its data is discarded.
//  run:
//  - Deassertion mid-program has no effect; only halt_req or the end conditions stop the program.
//  Widths: pc arithmetic is PC_BITS unsigned; the wrap is explicit, not modular, so PROG_LEN<2**PC_BITS works.
//  Illegal state encoding -> IDLE, instr=0.
// STRUCTURE
//  Shared package cpu_pkg:
//  - class codes CLS_NOP/STD/LOAD/STORE.
//  - HOLD_STD=3, HOLD_LOAD=4, HOLD_STORE=3.
//  - sequencer state encoding (must stay consistent with CU FSM cycle counts).
//  Single module. Hold lookup is a function in the package; no sub-module.
// TESTING
//  - Reset mid-ISSUE (rst=0 one cycle) -> next cycle instr=0, pc=0, busy=0, state IDLE.
//  - ROM {0x4_1203 std, 0x8_0010 load, 0xC_0020 store, 0x0_0000}, run=1
//    -> instr held 4, 4, 3 cycles; then done=1; CU regfile matches golden.
//  - PROG_LEN=3, loop_en=1, ROM all std_op
//    -> pc sequence 0, 1, 2, 0, 1...; prefetch addr 0 seen at pc=2, cnt=2.
//  - PROG_LEN=3, loop_en=0 -> after pc=2 completes, done=1; no imem_en after the cnt==2 cycle of pc=2.
//  - halt_req pulse in cycle 2 of a loadR -> loadR completes all 4 cycles; then DONE, instr=0.
//  - First ROM word class 00 -> FETCH, LOAD, DONE; instr never nonzero; the CU stays in RESET.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU: instruction class codes, per-class
// CU cycle counts and the sequencer state encoding.
package cpu_pkg;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  // Cycles the CU FSM spends on one instruction of each class.
  localparam logic [2:0] HOLD_STD   = 3'd3;  // DEC, EXE, WB
  localparam logic [2:0] HOLD_LOAD  = 3'd4;  // DEC, EXE, MEM, WB
  localparam logic [2:0] HOLD_STORE = 3'd3;  // DEC, EXE, MEM

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_FETCH = 3'd1,
    SEQ_LOAD  = 3'd2,
    SEQ_ISSUE = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

  // Hold count for a class; class 00 is never issued so it maps to 0.
  function automatic logic [2:0] hold_cycles(input logic [1:0] cls);
    case (cls)
      CLS_STD:   return HOLD_STD;
      CLS_LOAD:  return HOLD_LOAD;
      CLS_STORE: return HOLD_STORE;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches instructions from a synchronous ROM and holds
// each on `instr` for exactly the number of cycles the CU spends on it.
// The next instruction is prefetched two cycles before the boundary so that
// it lands on the same edge the CU re-enters DECODE.
//
// state     | meaning
// IDLE      | waiting for run; instr=0
// FETCH     | ROM read of pc issued
// LOAD      | ROM data valid; class 00 ends the program immediately
// ISSUE     | instruction on instr, cnt counts down to the boundary
// DONE      | program finished or halted; waits for run to drop
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int PROG_LEN    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   halt_req,
  input  logic                   loop_en,
  output logic                   imem_en,
  output logic [PC_BITS-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done
);

  localparam logic [PC_BITS-1:0] LAST_PC = PC_BITS'(PROG_LEN - 1);

  seq_state_e             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   halt_pend_q, halt_pend_d;
  logic                   end_q, end_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic                   imem_en_q, imem_en_d;
  logic [PC_BITS-1:0]     imem_addr_q, imem_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [1:0]             fetched_cls;

  assign fetched_cls = imem_data[INSTR_WIDTH-1 -: 2];

  // Next-state and registered-output computation for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
    end_d       = end_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    imem_en_d   = 1'b0;
    imem_addr_d = imem_addr_q;

    case (state_q)
      SEQ_IDLE: begin
        instr_d     = '0;
        pc_d        = '0;
        cnt_d       = '0;
        halt_pend_d = 1'b0;
        end_d       = 1'b0;
        if (run) begin
          state_d     = SEQ_FETCH;
          imem_en_d   = 1'b1;
          imem_addr_d = '0;
        end
      end
      SEQ_FETCH: begin
        halt_pend_d = halt_pend_q | halt_req;
        state_d     = SEQ_LOAD;
      end
      SEQ_LOAD: begin
        if (fetched_cls == CLS_NOP) begin
          state_d     = SEQ_DONE;
          instr_d     = '0;
          halt_pend_d = 1'b0;
        end else begin
          // Extra cycle covers the CU leaving RESET before its first DECODE.
          halt_pend_d = halt_pend_q | halt_req;
          state_d     = SEQ_ISSUE;
          instr_d     = imem_data;
          cnt_d       = hold_cycles(fetched_cls) + 3'd1;
        end
      end
      SEQ_ISSUE: begin
        halt_pend_d = halt_pend_q | halt_req;
        cnt_d       = cnt_q - 3'd1;
        // Registering the read here puts imem_en high during the cnt==2 cycle.
        if (cnt_q == 3'd3) begin
          if (pc_q == LAST_PC && !loop_en) begin
            end_d = 1'b1;
          end else begin
            imem_en_d   = 1'b1;
            imem_addr_d = (pc_q == LAST_PC) ? '0 : pc_q + PC_BITS'(1);
          end
        end
        if (cnt_q == 3'd1) begin
          if (halt_pend_q || halt_req || end_q || fetched_cls == CLS_NOP) begin
            state_d     = SEQ_DONE;
            instr_d     = '0;
            cnt_d       = '0;
            halt_pend_d = 1'b0;
          end else begin
            instr_d = imem_data;
            pc_d    = imem_addr_q;
            cnt_d   = hold_cycles(fetched_cls);
          end
        end
      end
      SEQ_DONE: begin
        instr_d     = '0;
        halt_pend_d = 1'b0;
        end_d       = 1'b0;
        if (!run) state_d = SEQ_IDLE;
      end
      default: begin
        state_d     = SEQ_IDLE;
        instr_d     = '0;
        pc_d        = '0;
        cnt_d       = '0;
        halt_pend_d = 1'b0;
        end_d       = 1'b0;
        imem_addr_d = '0;
      end
    endcase

    busy_d = (state_d == SEQ_FETCH) || (state_d == SEQ_LOAD) || (state_d == SEQ_ISSUE);
    done_d = (state_d == SEQ_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SEQ_IDLE;
      cnt_q       <= '0;
      halt_pend_q <= 1'b0;
      end_q       <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      imem_en_q   <= 1'b0;
      imem_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_pend_q <= halt_pend_d;
      end_q       <= end_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      imem_en_q   <= imem_en_d;
      imem_addr_q <= imem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign imem_en   = imem_en_q;
  assign imem_addr = imem_addr_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
